// File: rtl/parking_entry_ctrl.sv
// Parking lot entry controller: per-lane gate FSMs, round-robin entry
// arbitration and a shared occupancy counter driven by grants, gate
// timeouts and exit sensors.
module parking_entry_ctrl #(
  parameter int CAP_W       = 8,
  parameter int CAPACITY    = 200,
  parameter int N_ENTRY     = 2,
  parameter int N_EXIT      = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_ENTRY-1:0] entry_req,
  input  logic [N_ENTRY-1:0] entry_pass,
  input  logic [N_EXIT-1:0]  exit_pulse,
  output logic [N_ENTRY-1:0] gate_open,
  output logic [N_ENTRY-1:0] entry_grant,
  output logic [CAP_W-1:0]   occupancy,
  output logic [CAP_W-1:0]   free_spaces,
  output logic               full,
  output logic               exit_err
);

  localparam int PTR_W = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int SUM_W = CAP_W + 2;

  localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]        TMR_ONE  = TMR_W'(1);
  localparam logic [CAP_W-1:0]        CAP_V    = CAP_W'(CAPACITY);
  localparam logic signed [SUM_W-1:0] ONE_S    = SUM_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } lane_state_t;

  lane_state_t        state_q [N_ENTRY];
  lane_state_t        state_d [N_ENTRY];
  logic [TMR_W-1:0]   timer_q [N_ENTRY];
  logic [TMR_W-1:0]   timer_d [N_ENTRY];
  logic [PTR_W-1:0]   rr_q;
  logic [PTR_W-1:0]   rr_d;
  logic [N_ENTRY-1:0] eligible;
  logic [N_ENTRY-1:0] grant_vec;
  logic [N_ENTRY-1:0] timeout_vec;
  logic [N_ENTRY-1:0] gate_d;
  logic               can_admit;
  logic               found;

  logic signed [SUM_W-1:0] occ_sum;
  logic [CAP_W-1:0]        occ_d;
  logic [CAP_W-1:0]        free_d;
  logic                    full_d;
  logic                    err_d;

  // State register: lane FSMs, timers, arbiter pointer and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
      rr_q        <= '0;
      occupancy   <= '0;
      free_spaces <= CAP_V;
      full        <= 1'b0;
      gate_open   <= '0;
      entry_grant <= '0;
      exit_err    <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      rr_q        <= rr_d;
      occupancy   <= occ_d;
      free_spaces <= free_d;
      full        <= full_d;
      gate_open   <= gate_d;
      entry_grant <= grant_vec;
      exit_err    <= err_d;
    end
  end

  // Round-robin arbiter over idle lanes with a waiting car, gated on pre-update occupancy
  always_comb begin
    grant_vec = '0;
    rr_d      = rr_q;
    found     = 1'b0;
    can_admit = (occupancy < CAP_V);
    for (int i = 0; i < N_ENTRY; i++) begin
      eligible[i] = (state_q[i] == IDLE) && entry_req[i];
    end
    if (can_admit) begin
      for (int k = 0; k < N_ENTRY; k++) begin
        for (int i = 0; i < N_ENTRY; i++) begin
          if (!found && (i == (int'(rr_q) + k) % N_ENTRY) && eligible[i]) begin
            grant_vec[i] = 1'b1;
            rr_d         = PTR_W'((i + 1) % N_ENTRY);
            found        = 1'b1;
          end
        end
      end
    end
  end

  // Lane next-state logic: a pass beats a coinciding timeout, and a timeout releases the reservation
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      state_d[i]     = state_q[i];
      timer_d[i]     = timer_q[i];
      timeout_vec[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          timer_d[i] = '0;
          if (grant_vec[i]) begin
            state_d[i] = OPEN;
          end
        end
        OPEN: begin
          if (entry_pass[i]) begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
          end else if (timer_q[i] == TMR_LAST) begin
            state_d[i]     = IDLE;
            timer_d[i]     = '0;
            timeout_vec[i] = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] + TMR_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  // Net occupancy change for the cycle; going negative clamps to zero and raises the sticky error
  always_comb begin
    occ_sum = {2'b00, occupancy};
    err_d   = exit_err;
    if (|grant_vec) begin
      occ_sum = occ_sum + ONE_S;
    end
    for (int i = 0; i < N_ENTRY; i++) begin
      if (timeout_vec[i]) begin
        occ_sum = occ_sum - ONE_S;
      end
    end
    for (int j = 0; j < N_EXIT; j++) begin
      if (exit_pulse[j]) begin
        occ_sum = occ_sum - ONE_S;
      end
    end
    if (occ_sum[SUM_W-1]) begin
      occ_d = '0;
      err_d = 1'b1;
    end else begin
      occ_d = occ_sum[CAP_W-1:0];
    end
  end

  // Output decode for the next cycle: gate commands and counters derived from the same next occupancy
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      gate_d[i] = (state_d[i] == OPEN);
    end
    free_d = CAP_V - occ_d;
    full_d = (occ_d == CAP_V);
  end

endmodule

// File: tb/tb_parking_entry_ctrl.sv
// Self-checking bench for parking_entry_ctrl: a default-sized instance and
// a small instance (3 spaces, 4-cycle gate timeout) driven from stimulus
// tables; expected outputs flow through a scoreboard queue.
module tb_parking_entry_ctrl;

  typedef struct packed {
    logic [1:0] grant;
    logic [1:0] gate;
    logic [7:0] occ;
    logic [7:0] free;
    logic       full;
    logic       err;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] req;
    logic [1:0] pass;
    logic [1:0] ext;
    obs_t       exp;
  } row_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] a_req, a_pass, a_exit, a_gate, a_grant;
  logic [7:0] a_occ, a_free;
  logic       a_full, a_err;
  logic [1:0] b_req, b_pass, b_exit, b_gate, b_grant;
  logic [7:0] b_occ, b_free;
  logic       b_full, b_err;

  obs_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  parking_entry_ctrl dut_a (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (a_req),
    .entry_pass (a_pass),
    .exit_pulse (a_exit),
    .gate_open  (a_gate),
    .entry_grant(a_grant),
    .occupancy  (a_occ),
    .free_spaces(a_free),
    .full       (a_full),
    .exit_err   (a_err)
  );

  parking_entry_ctrl #(.CAPACITY(3), .TIMEOUT_CYC(4)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (b_req),
    .entry_pass (b_pass),
    .exit_pulse (b_exit),
    .gate_open  (b_gate),
    .entry_grant(b_grant),
    .occupancy  (b_occ),
    .free_spaces(b_free),
    .full       (b_full),
    .exit_err   (b_err)
  );

  // Build one stimulus row; free/full are derived from the lot capacity and expected occupancy
  function automatic row_t mk(int cap, bit rst, logic [1:0] req, logic [1:0] pass,
                              logic [1:0] ext, logic [1:0] grant, logic [1:0] gate,
                              int occ, bit err);
    row_t r;
    r.rst       = rst;
    r.req       = req;
    r.pass      = pass;
    r.ext       = ext;
    r.exp.grant = grant;
    r.exp.gate  = gate;
    r.exp.occ   = 8'(occ);
    r.exp.free  = 8'(cap - occ);
    r.exp.full  = (occ == cap);
    r.exp.err   = err;
    return r;
  endfunction

  function automatic obs_t sample(bit which);
    if (which) return {b_grant, b_gate, b_occ, b_free, b_full, b_err};
    return {a_grant, a_gate, a_occ, a_free, a_full, a_err};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("grant=%b gate=%b occ=%0d free=%0d full=%b err=%b",
                     o.grant, o.gate, o.occ, o.free, o.full, o.err);
  endfunction

  task automatic drive(bit which, row_t r);
    reset = r.rst;
    if (which) begin
      b_req = r.req; b_pass = r.pass; b_exit = r.ext;
      a_req = '0;    a_pass = '0;     a_exit = '0;
    end else begin
      a_req = r.req; a_pass = r.pass; a_exit = r.ext;
      b_req = '0;    b_pass = '0;     b_exit = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = '0; a_pass = '0; a_exit = '0;
    b_req = '0; b_pass = '0; b_exit = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t act, exp;
    for (int c = 0; c < 2; c++) begin
      reset = 1'b1;
      a_req = 2'b11; a_pass = 2'b11; a_exit = 2'b11;
      b_req = 2'b11; b_pass = 2'b11; b_exit = 2'b11;
      sb.push_back(mk(200, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0).exp);
      sb.push_back(mk(3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0).exp);
      @(posedge clk); #1;
      for (int w = 0; w < 2; w++) begin
        act = sample(w[0]);
        exp = sb.pop_front();
        n_cmp++;
        if (act !== exp) begin
          n_fail++;
          $display("[TB] FAIL reset dut%0d cycle %0d: got %s need %s", w, c, fmt(act), fmt(exp));
        end
      end
    end
  endtask

  task automatic test_single_entry();
    row_t rows[$];
    obs_t act, exp;
    rows.push_back(mk(200, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0));
    for (int c = 0; c < 4; c++)
      rows.push_back(mk(200, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0));
    rows.push_back(mk(200, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
    rows.push_back(mk(200, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
    foreach (rows[k]) begin
      drive(1'b0, rows[k]);
      sb.push_back(rows[k].exp);
      @(posedge clk); #1;
      act = sample(1'b0);
      exp = sb.pop_front();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("[TB] FAIL single_entry step %0d: got %s need %s", k, fmt(act), fmt(exp));
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    obs_t act, exp;
    do_reset();
    rows.push_back(mk(200, 0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0));
    rows.push_back(mk(200, 0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2, 0));
    rows.push_back(mk(200, 0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10, 2, 0));
    rows.push_back(mk(200, 0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 3, 0));
    rows.push_back(mk(200, 0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 4, 0));
    rows.push_back(mk(200, 0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10, 4, 0));
    rows.push_back(mk(200, 0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 5, 0));
    rows.push_back(mk(200, 0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 6, 0));
    rows.push_back(mk(200, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 6, 0));
    rows.push_back(mk(200, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 6, 0));
    foreach (rows[k]) begin
      drive(1'b0, rows[k]);
      sb.push_back(rows[k].exp);
      @(posedge clk); #1;
      act = sample(1'b0);
      exp = sb.pop_front();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("[TB] FAIL round_robin step %0d: got %s need %s", k, fmt(act), fmt(exp));
      end
    end
  endtask

  task automatic test_exit_underflow();
    row_t rows[$];
    obs_t act, exp;
    do_reset();
    rows.push_back(mk(200, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0));
    rows.push_back(mk(200, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
    rows.push_back(mk(200, 0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 1, 0));
    rows.push_back(mk(200, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
    rows.push_back(mk(200, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1));
    rows.push_back(mk(200, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
    rows.push_back(mk(200, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0, 1));
    foreach (rows[k]) begin
      drive(1'b0, rows[k]);
      sb.push_back(rows[k].exp);
      @(posedge clk); #1;
      act = sample(1'b0);
      exp = sb.pop_front();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("[TB] FAIL exit_underflow step %0d: got %s need %s", k, fmt(act), fmt(exp));
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    obs_t act, exp;
    for (int n = 1; n <= 4; n++) begin
      rows.push_back(mk(200, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, n, 1));
      rows.push_back(mk(200, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, n, 1));
    end
    rows.push_back(mk(200, 0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 5, 1));
    rows.push_back(mk(200, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 5, 1));
    rows.push_back(mk(200, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0));
    rows.push_back(mk(200, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    rows.push_back(mk(200, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0));
    foreach (rows[k]) begin
      drive(1'b0, rows[k]);
      sb.push_back(rows[k].exp);
      @(posedge clk); #1;
      act = sample(1'b0);
      exp = sb.pop_front();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("[TB] FAIL reset_mid step %0d: got %s need %s", k, fmt(act), fmt(exp));
      end
    end
  endtask

  task automatic test_capacity_full();
    row_t rows[$];
    obs_t act, exp;
    do_reset();
    rows.push_back(mk(3, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0));
    rows.push_back(mk(3, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
    rows.push_back(mk(3, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2, 0));
    rows.push_back(mk(3, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2, 0));
    rows.push_back(mk(3, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 3, 0));
    rows.push_back(mk(3, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 3, 0));
    rows.push_back(mk(3, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3, 0));
    rows.push_back(mk(3, 0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2, 0));
    rows.push_back(mk(3, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 3, 0));
    rows.push_back(mk(3, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 3, 0));
    foreach (rows[k]) begin
      drive(1'b1, rows[k]);
      sb.push_back(rows[k].exp);
      @(posedge clk); #1;
      act = sample(1'b1);
      exp = sb.pop_front();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("[TB] FAIL capacity_full step %0d: got %s need %s", k, fmt(act), fmt(exp));
      end
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    obs_t act, exp;
    do_reset();
    rows.push_back(mk(3, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0));
    for (int c = 0; c < 3; c++)
      rows.push_back(mk(3, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0));
    rows.push_back(mk(3, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    rows.push_back(mk(3, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0));
    for (int c = 0; c < 3; c++)
      rows.push_back(mk(3, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0));
    rows.push_back(mk(3, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
    rows.push_back(mk(3, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
    rows.push_back(mk(3, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
    foreach (rows[k]) begin
      drive(1'b1, rows[k]);
      sb.push_back(rows[k].exp);
      @(posedge clk); #1;
      act = sample(1'b1);
      exp = sb.pop_front();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("[TB] FAIL timeout step %0d: got %s need %s", k, fmt(act), fmt(exp));
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    reset = 1'b1;
    a_req = '0; a_pass = '0; a_exit = '0;
    b_req = '0; b_pass = '0; b_exit = '0;
    test_reset();
    test_single_entry();
    test_round_robin();
    test_exit_underflow();
    test_reset_mid();
    test_capacity_full();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
